// File: rtl/lcd_pkg.sv
// Shared types and constants for the 2x16 character-LCD line sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LADDR,
    ST_DATA,
    ST_FIN
  } lcd_state_t;

  localparam logic       LCD_ADDR_INSTR = 1'b0;
  localparam logic       LCD_ADDR_DATA  = 1'b1;

  localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
  localparam logic [7:0] LCD_CMD_LINE0  = 8'h80;
  localparam logic [7:0] LCD_CMD_LINE1  = 8'hC0;
  localparam logic [7:0] LCD_BLANK      = 8'h20;

  localparam int         LCD_COLS       = 16;

endpackage

// File: rtl/lcd_line_buffer.sv
// Two-line character shadow buffer: one write port, one combinational read port.
module lcd_line_buffer
  import lcd_pkg::*;
#(
  parameter int         COLS       = LCD_COLS,
  parameter logic [7:0] BLANK_CHAR = LCD_BLANK
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     we,
  input  logic                     wr_line,
  input  logic [$clog2(COLS)-1:0]  wr_col,
  input  logic [7:0]               wr_char,
  input  logic                     rd_line,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  output logic [7:0]               rd_char
);

  localparam int            CW     = $clog2(COLS);
  localparam logic [CW:0]   COLS_V = (CW+1)'(COLS);

  logic [7:0] mem [2][COLS];
  logic       wr_ok;
  logic       rd_ok;

  // Column indices past the last column are dropped on write and read as blank.
  assign wr_ok = ({1'b0, wr_col} < COLS_V);
  assign rd_ok = ({1'b0, rd_col} < COLS_V);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < 2; l++) begin
        for (int c = 0; c < COLS; c++) begin
          mem[l][c] <= BLANK_CHAR;
        end
      end
    end else if (we && wr_ok) begin
      mem[wr_line][wr_col] <= wr_char;
    end
  end

  assign rd_char = rd_ok ? mem[rd_line][rd_col] : BLANK_CHAR;

endmodule

// File: rtl/lcd_line_sequencer.sv
// Avalon-MM master that replays a 2-line shadow buffer to a character LCD slave
// (address 0 = instruction, 1 = data), with optional display clear first.
module lcd_line_sequencer
  import lcd_pkg::*;
#(
  parameter int         COLS         = LCD_COLS,
  parameter logic [7:0] LINE0_ADDR   = LCD_CMD_LINE0,
  parameter logic [7:0] LINE1_ADDR   = LCD_CMD_LINE1,
  parameter logic [7:0] CLEAR_CMD    = LCD_CMD_CLEAR,
  parameter logic [7:0] BLANK_CHAR   = LCD_BLANK,
  parameter bit         AUTO_REFRESH = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     buf_we,
  input  logic                     buf_line,
  input  logic [$clog2(COLS)-1:0]  buf_col,
  input  logic [7:0]               buf_char,
  input  logic                     refresh_req,
  input  logic                     clear_req,
  output logic                     busy,
  output logic                     done,
  output logic                     address,
  output logic                     chipselect,
  output logic                     write,
  output logic [7:0]               writedata,
  input  logic                     waitrequest
);

  localparam int            CW       = $clog2(COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW:0]   COLS_V   = (CW+1)'(COLS);

  lcd_state_t      state;
  logic            line;
  logic [CW-1:0]   col;
  logic            pend_refresh;
  logic            pend_clear;
  logic            auto_hit;
  logic            rd_line;
  logic [CW-1:0]   rd_col;
  logic [7:0]      rd_char;

  lcd_line_buffer #(
    .COLS       (COLS),
    .BLANK_CHAR (BLANK_CHAR)
  ) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (buf_we),
    .wr_line (buf_line),
    .wr_col  (buf_col),
    .wr_char (buf_char),
    .rd_line (rd_line),
    .rd_col  (rd_col),
    .rd_char (rd_char)
  );

  assign auto_hit = AUTO_REFRESH && buf_we && ({1'b0, buf_col} < COLS_V);

  // Read port always points at the cell that will be driven after the next acceptance.
  always_comb begin
    rd_line = line;
    rd_col  = '0;
    if (state == ST_DATA) begin
      rd_col = col + 1'b1;
    end
  end

  assign busy = (state != ST_IDLE) | pend_refresh | pend_clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      line         <= 1'b0;
      col          <= '0;
      pend_refresh <= 1'b0;
      pend_clear   <= 1'b0;
      address      <= 1'b0;
      chipselect   <= 1'b0;
      write        <= 1'b0;
      writedata    <= '0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state != ST_IDLE) begin
        if (refresh_req || auto_hit) pend_refresh <= 1'b1;
        if (clear_req)               pend_clear   <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (clear_req || pend_clear) begin
            // A clear sequence already carries a full refresh, so it absorbs any pending one.
            state        <= ST_CLEAR;
            pend_clear   <= 1'b0;
            pend_refresh <= 1'b0;
            chipselect   <= 1'b1;
            write        <= 1'b1;
            address      <= LCD_ADDR_INSTR;
            writedata    <= CLEAR_CMD;
          end else if (refresh_req || pend_refresh) begin
            state        <= ST_LADDR;
            line         <= 1'b0;
            pend_refresh <= 1'b0;
            chipselect   <= 1'b1;
            write        <= 1'b1;
            address      <= LCD_ADDR_INSTR;
            writedata    <= LINE0_ADDR;
          end else if (auto_hit) begin
            pend_refresh <= 1'b1;
          end
        end

        ST_CLEAR: begin
          if (!waitrequest) begin
            state     <= ST_LADDR;
            line      <= 1'b0;
            address   <= LCD_ADDR_INSTR;
            writedata <= LINE0_ADDR;
          end
        end

        ST_LADDR: begin
          if (!waitrequest) begin
            state     <= ST_DATA;
            col       <= '0;
            address   <= LCD_ADDR_DATA;
            writedata <= rd_char;
          end
        end

        ST_DATA: begin
          if (!waitrequest) begin
            if (col != LAST_COL) begin
              col       <= col + 1'b1;
              writedata <= rd_char;
            end else if (!line) begin
              state     <= ST_LADDR;
              line      <= 1'b1;
              address   <= LCD_ADDR_INSTR;
              writedata <= LINE1_ADDR;
            end else begin
              state      <= ST_FIN;
              chipselect <= 1'b0;
              write      <= 1'b0;
              address    <= LCD_ADDR_INSTR;
              writedata  <= '0;
              done       <= 1'b1;
            end
          end
        end

        ST_FIN: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_line_sequencer.sv
// Randomized self-checking bench for lcd_line_sequencer against a shadow-buffer transfer model.
module tb_lcd_line_sequencer;

  localparam int COLS = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       buf_we = 1'b0;
  logic       buf_line = 1'b0;
  logic [3:0] buf_col = '0;
  logic [7:0] buf_char = '0;
  logic       refresh_req = 1'b0;
  logic       clear_req = 1'b0;
  logic       waitrequest = 1'b0;
  logic       busy, done, address, chipselect, write;
  logic [7:0] writedata;

  lcd_line_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .buf_we      (buf_we),
    .buf_line    (buf_line),
    .buf_col     (buf_col),
    .buf_char    (buf_char),
    .refresh_req (refresh_req),
    .clear_req   (clear_req),
    .busy        (busy),
    .done        (done),
    .address     (address),
    .chipselect  (chipselect),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest)
  );

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad = 0;
  logic [7:0] shadow [2][COLS];
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  // Every accepted Avalon write, as {address, writedata}.
  always @(negedge clk) begin
    if (reset_n && chipselect && write && !waitrequest) got_q.push_back({address, writedata});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input bit with_clear);
    exp_q.delete();
    if (with_clear) exp_q.push_back({1'b0, 8'h01});
    for (int l = 0; l < 2; l++) begin
      exp_q.push_back({1'b0, (l == 0) ? 8'h80 : 8'hC0});
      for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, shadow[l][c]});
    end
  endtask

  task automatic buf_write(input int l, input int c, input logic [7:0] ch);
    buf_we   = 1'b1;
    buf_line = l[0];
    buf_col  = c[3:0];
    buf_char = ch;
    tick;
    buf_we   = 1'b0;
    shadow[l][c] = ch;
  endtask

  // kind: 0 refresh, 1 clear, 2 clear+refresh together
  task automatic run_seq(input string tag, input int kind, input int stall_idx,
                         input int exp_done, input int exp_wcyc, input bit extra,
                         input bit rnd_wait, input bit mid_write);
    int          n = 0;
    int          dones = 0;
    int          first_done = 0;
    int          wcyc = 0;
    int          stall_left = 0;
    int          busy_low = 0;
    int          want;
    int          base;
    bit          stalled = 1'b0;
    logic [10:0] held = '0;
    logic [8:0]  exp_all[$];
    got_q.delete();
    build_exp(kind != 0);
    base = (kind != 0) ? 1 : 0;
    want = extra ? 2 : 1;
    if (mid_write) exp_q[base + 23] = {1'b1, 8'h5A};
    refresh_req = (kind != 1);
    clear_req   = (kind != 0);
    while (dones < want && n < 400) begin
      tick;
      n++;
      if (n == 1) begin
        refresh_req = 1'b0;
        clear_req   = 1'b0;
        chk({tag, "_first_write"}, write, 1);
      end
      if (extra) refresh_req = (n == 5 || n == 10 || n == 15);
      if (extra && !busy) busy_low++;
      if (dones == 0 && write) wcyc++;
      if (done) begin
        dones++;
        if (dones == 1) first_done = n;
      end
      if (mid_write) begin
        if (n == 3) begin
          buf_we = 1'b1; buf_line = 1'b0; buf_col = 4'd0; buf_char = 8'h51;
          shadow[0][0] = 8'h51;
        end else if (n == 4) begin
          buf_line = 1'b1; buf_col = 4'd5; buf_char = 8'h5A;
          shadow[1][5] = 8'h5A;
        end else begin
          buf_we = 1'b0;
        end
      end
      if (stall_left > 0) begin
        chk({tag, "_stall_hold"}, {chipselect, write, address, writedata}, held);
        stall_left--;
        if (stall_left == 0) waitrequest = 1'b0;
      end else if (stall_idx >= 0 && !stalled && write && got_q.size() == stall_idx) begin
        stalled     = 1'b1;
        waitrequest = 1'b1;
        stall_left  = 5;
        held        = {chipselect, write, address, writedata};
      end
      if (rnd_wait) waitrequest = ($urandom_range(0, 3) == 0);
    end
    waitrequest = 1'b0;
    refresh_req = 1'b0;
    clear_req   = 1'b0;
    buf_we      = 1'b0;
    tick;
    chk({tag, "_done_pulse"}, done, 0);
    tick;
    tick;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_seen"}, dones, want);
    if (exp_done > 0) chk({tag, "_done_cycle"}, first_done, exp_done);
    if (exp_wcyc > 0) chk({tag, "_write_cycles"}, wcyc, exp_wcyc);
    if (extra) chk({tag, "_busy_held"}, busy_low, 0);
    exp_all = exp_q;
    if (extra) exp_all = {exp_q, exp_q};
    chk({tag, "_count"}, got_q.size(), exp_all.size());
    for (int i = 0; i < exp_all.size() && i < got_q.size(); i++)
      chk($sformatf("%s_xfer%0d", tag, i), got_q[i], exp_all[i]);
  endtask

  initial begin
    int n;
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < COLS; c++) shadow[l][c] = 8'h20;

    // Reset and quiet idle
    tick;
    tick;
    chk("rst_outputs", {address, chipselect, write, writedata, busy, done}, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    chk("idle_outputs", {address, chipselect, write, writedata, busy, done}, 0);
    chk("idle_no_xfer", got_q.size(), 0);
    run_seq("blank", 0, -1, 35, 34, 1'b0, 1'b0, 1'b0);

    // HELLO on line 0, 'A' at the last cell of line 1
    buf_write(0, 0, 8'h48);
    buf_write(0, 1, 8'h45);
    buf_write(0, 2, 8'h4C);
    buf_write(0, 3, 8'h4C);
    buf_write(0, 4, 8'h4F);
    buf_write(1, 15, 8'h41);
    tick;
    chk("write_no_busy", busy, 0);
    run_seq("hello", 0, -1, 35, 34, 1'b0, 1'b0, 1'b0);

    run_seq("stall", 0, 2, 40, 39, 1'b0, 1'b0, 1'b0);
    run_seq("merge", 0, -1, 35, 34, 1'b1, 1'b0, 1'b0);
    run_seq("clear", 1, -1, 36, 35, 1'b0, 1'b0, 1'b0);
    run_seq("both", 2, -1, 36, 35, 1'b0, 1'b0, 1'b0);
    run_seq("coher", 0, -1, 35, 34, 1'b0, 1'b0, 1'b1);
    run_seq("coher2", 0, -1, 35, 34, 1'b0, 1'b0, 1'b0);

    for (int it = 0; it < 4; it++) begin
      int nw;
      nw = $urandom_range(1, 10);
      for (int w = 0; w < nw; w++)
        buf_write($urandom_range(0, 1), $urandom_range(0, COLS - 1), 8'($urandom_range(32, 126)));
      run_seq($sformatf("rnd%0d", it), $urandom_range(0, 1), -1, 0, 0, 1'b0, 1'b1, 1'b0);
    end

    // Reset in the middle of line-0 data with a refresh also pending
    got_q.delete();
    refresh_req = 1'b1;
    tick;
    refresh_req = 1'b1;
    tick;
    refresh_req = 1'b0;
    n = 0;
    while (!(write && address && got_q.size() == 8) && n < 100) begin
      tick;
      n++;
    end
    chk("rst_reach_col7", got_q.size(), 8);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_drop_cs", chipselect, 0);
    chk("rst_drop_write", write, 0);
    chk("rst_busy", busy, 0);
    tick;
    tick;
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    chk("rst_no_resume", got_q.size(), 8);
    chk("rst_idle_busy", busy, 0);
    chk("rst_idle_write", write, 0);
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < COLS; c++) shadow[l][c] = 8'h20;
    run_seq("after_rst", 0, -1, 35, 34, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
